// File: rtl/btn_pkg.sv
// Shared state encoding and timing defaults for the button_debounce front end.
package btn_pkg;

    typedef enum logic [1:0] {
        REL     = 2'd0,
        REL_CHK = 2'd1,
        PRS     = 2'd2,
        PRS_CHK = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_10MS_12M   = 120000;
    localparam int REPEAT_DELAY_500MS  = 6000000;
    localparam int REPEAT_PERIOD_100MS = 1200000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce FSM.
// Auto-repeat of the press pulse is built only with BTN_REPEAT_EN defined.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12M,
`ifdef BTN_REPEAT_EN
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
`endif
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [1:0]    sync_q;
    btn_state_e    st_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          press_q;
    logic          rel_q;
    logic          p;
    logic          s;
    logic          acc_press;
    logic          rep_fire;

    assign p = pad_i ^ ACTIVE_LOW;
    assign s = sync_q[1];

    assign acc_press = (st_q == REL_CHK) && s && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], p};
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 2);
    localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q;
    logic          rep_q;
    logic          in_prs;

    assign in_prs   = (st_q == PRS) || (st_q == PRS_CHK);
    assign rep_fire = in_prs && (rcnt_q == (rep_q ? R_NEXT : R_FIRST));

    // Timing is anchored to the accepted press, so a release glitch
    // that falls back to PRS does not restart the repeat schedule.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else if (acc_press) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else if (rep_fire) begin
            rcnt_q <= '0;
            rep_q  <= 1'b1;
        end else if (in_prs) begin
            rcnt_q <= rcnt_q + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= REL;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            unique case (st_q)
                REL: begin
                    if (s) begin
                        st_q  <= REL_CHK;
                        cnt_q <= '0;
                    end
                end
                REL_CHK: begin
                    if (!s) begin
                        st_q  <= REL;
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        st_q    <= PRS;
                        cnt_q   <= '0;
                        lvl_q   <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRS: begin
                    press_q <= rep_fire;
                    if (!s) begin
                        st_q  <= PRS_CHK;
                        cnt_q <= '0;
                    end
                end
                PRS_CHK: begin
                    if (s) begin
                        st_q    <= PRS;
                        cnt_q   <= '0;
                        press_q <= rep_fire;
                    end else if (cnt_q == CNT_LAST) begin
                        st_q  <= REL;
                        cnt_q <= '0;
                        lvl_q <= 1'b0;
                        rel_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        press_q <= rep_fire;
                    end
                end
                default: begin
                    st_q  <= REL;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign state_o   = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/button_debounce.sv
// N-channel debounced button front end with press/release pulses.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while held.
module button_debounce
    import btn_pkg::*;
#(
    parameter int N_BUTTONS       = 6,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12M,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input  logic                 CLK12,
    input  logic                 RESET,
    input  logic [N_BUTTONS-1:0] BTN_IN,
    output logic [N_BUTTONS-1:0] BTN_STATE,
    output logic [N_BUTTONS-1:0] BTN_PRESS,
    output logic [N_BUTTONS-1:0] BTN_RELEASE,
    output logic                 BTN_ANY
);

    localparam bit CFG_OK = (N_BUTTONS >= 1) && (N_BUTTONS <= 32)
                         && (DEBOUNCE_CYCLES >= 2)
                         && (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 1);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("button_debounce: parameters out of range");
        end
    endgenerate

    logic any_q;

    genvar i;
    generate
        for (i = 0; i < N_BUTTONS; i++) begin : g_chan
            btn_debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef BTN_REPEAT_EN
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_chan (
                .clk_i    (CLK12),
                .rst_i    (RESET),
                .pad_i    (BTN_IN[i]),
                .state_o  (BTN_STATE[i]),
                .press_o  (BTN_PRESS[i]),
                .release_o(BTN_RELEASE[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |BTN_STATE;
        end
    end

    assign BTN_ANY = any_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed plus randomized bench for button_debounce, two polarities.
module tb_button_debounce;

    localparam int N  = 6;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_n = '0;
    logic [N-1:0] in_al = '1;
    logic [N-1:0] st0, pr0, rl0, st1, pr1, rl1;
    logic         any0, any1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLK12(clk), .RESET(rst), .BTN_IN(in_n),
        .BTN_STATE(st0), .BTN_PRESS(pr0), .BTN_RELEASE(rl0), .BTN_ANY(any0)
    );

    button_debounce #(
        .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_al (
        .CLK12(clk), .RESET(rst), .BTN_IN(in_al),
        .BTN_STATE(st1), .BTN_PRESS(pr1), .BTN_RELEASE(rl1), .BTN_ANY(any1)
    );

    // Reference: pressed-space samples delayed two edges; the level flips
    // once D consecutive samples disagree with it.
    logic [N-1:0] m_d1 [2];
    logic [N-1:0] m_d2 [2];
    logic [N-1:0] m_lvl[2];
    logic [N-1:0] m_pr [2];
    logic [N-1:0] m_rl [2];
    logic         m_any[2];
    int           m_run [2][N];
    int           m_held[2][N];

    task automatic model_clear();
        for (int b = 0; b < 2; b++) begin
            m_d1[b]  = '0;
            m_d2[b]  = '0;
            m_lvl[b] = '0;
            m_pr[b]  = '0;
            m_rl[b]  = '0;
            m_any[b] = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_run[b][c]  = 0;
                m_held[b][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] p;
        logic [N-1:0] s;
        for (int b = 0; b < 2; b++) begin
            p = (b == 0) ? in_n : ~in_al;
            s = m_d2[b];
            m_d2[b]  = m_d1[b];
            m_d1[b]  = p;
            m_any[b] = |m_lvl[b];
            m_pr[b]  = '0;
            m_rl[b]  = '0;
            for (int c = 0; c < N; c++) begin
                if (s[c] != m_lvl[b][c]) m_run[b][c]++;
                else m_run[b][c] = 0;
                if (m_run[b][c] == D) begin
                    m_run[b][c]  = 0;
                    m_held[b][c] = 0;
                    m_lvl[b][c]  = s[c];
                    if (s[c]) m_pr[b][c] = 1'b1;
                    else m_rl[b][c] = 1'b1;
                end else if (m_lvl[b][c]) begin
                    m_held[b][c]++;
                    if (REP && (m_held[b][c] == RD - 1 ||
                        (m_held[b][c] > RD - 1 &&
                         (m_held[b][c] - (RD - 1)) % RP == 0)))
                        m_pr[b][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else model_edge();
        #1;
        chk("m_state0", 32'(st0), 32'(m_lvl[0]));
        chk("m_press0", 32'(pr0), 32'(m_pr[0]));
        chk("m_rel0",   32'(rl0), 32'(m_rl[0]));
        chk("m_any0",   32'(any0), 32'(m_any[0]));
        chk("m_state1", 32'(st1), 32'(m_lvl[1]));
        chk("m_press1", 32'(pr1), 32'(m_pr[1]));
        chk("m_rel1",   32'(rl1), 32'(m_rl[1]));
        chk("m_any1",   32'(any1), 32'(m_any[1]));
    endtask

    initial begin
        logic [5:0] bp;
        logic       ex;
        int         rate;
        model_clear();

        // Reset held while pads toggle
        for (int i = 0; i < 6; i++) begin
            in_n  = N'($urandom);
            in_al = N'($urandom);
            tick();
            chk("rst_zero", 32'({st0, pr0, rl0, any0}), 32'd0);
            chk("rst_zero_al", 32'({st1, pr1, rl1, any1}), 32'd0);
        end

        // Button held through reset release; active-low bank too
        in_n  = 6'b000001;
        in_al = 6'b111110;
        rst   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rst_press0", 32'(pr0), (i == 5) ? 32'd1 : 32'd0);
            chk("rst_state0", 32'(st0), (i >= 5) ? 32'd1 : 32'd0);
            chk("any_lag", 32'(any0), (i >= 6) ? 32'd1 : 32'd0);
            chk("al_state", 32'(st1), (i >= 5) ? 32'd1 : 32'd0);
        end

        // Bounce on channel 2: 1,1,0,1,1,0 then held
        bp = 6'b011011;
        for (int k = 0; k < 6; k++) begin
            in_n[2] = bp[k];
            tick();
            chk("bounce_pr", 32'(pr0[2]), 32'd0);
            chk("bounce_st", 32'(st0[2]), 32'd0);
        end
        in_n[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bounce_hold", 32'(pr0[2]), (i == 5) ? 32'd1 : 32'd0);
        end

        // Release on channel 3
        in_n[3] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rel_held", 32'(st0[3]), 32'd1);
        in_n[3] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rel_pulse", 32'(rl0[3]), (i == 5) ? 32'd1 : 32'd0);
            chk("rel_nopress", 32'(pr0[3]), 32'd0);
        end
        chk("rel_state", 32'(st0[3]), 32'd0);

        // Channels 1 and 5 rise together
        in_n[1] = 1'b1;
        in_n[5] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("simul", 32'(pr0), (i == 5) ? 32'h22 : 32'd0);
        end

        // Long hold on channel 4; release lands on a repeat slot (72)
        in_n[4] = 1'b1;
        for (int i = 0; i < 67; i++) begin
            tick();
            ex = (i == 5) || (REP && i >= 24 && (i - 24) % RP == 0);
            chk("repeat", 32'(pr0[4]), 32'(ex));
        end
        in_n[4] = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            chk("rep_rel", 32'(rl0[4]), (j == 5) ? 32'd1 : 32'd0);
            chk("rep_stop", 32'(pr0[4]), 32'd0);
        end

        // Random traffic with varying bounce density
        rate = 4;
        for (int t = 0; t < 400; t++) begin
            if (t % 40 == 0) rate = $urandom_range(2, 20);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, rate - 1) == 0) in_n[c]  = ~in_n[c];
                if ($urandom_range(0, rate - 1) == 0) in_al[c] = ~in_al[c];
            end
            tick();
            if (t == 200) begin
                #2;
                rst = 1'b1;
                #1;
                chk("async_rst", 32'({st0, pr0, rl0, any0}), 32'd0);
                chk("async_rst_al", 32'({st1, pr1, rl1, any1}), 32'd0);
                tick();
                tick();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
